// File: rtl/proc_pkg.sv
// Shared processor definitions: data-memory geometry, arbiter FSM state
// encoding and access-owner encoding.
package proc_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RDWAIT = 2'd2;

  localparam logic CORE = 1'b0;
  localparam logic HOST = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin choice. On a tie the side that was not served last
// wins; a lone request always wins.
module rr_pick2
  import proc_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic grant_a,
  output logic grant_b
);

  // a is the core side, b is the host side
  always_comb begin
    grant_a = req_a & (~req_b | (last == HOST));
    grant_b = req_b & (~req_a | (last == CORE));
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Core/host arbiter and strobe sequencer for the single-port data memory.
//
// state  | meaning
// IDLE   | no access in flight; requests evaluated, grant issued here
// ACCESS | memory strobe cycle driven from the captured request
// RDWAIT | read data returned by the memory, routed to the owner
module dmem_port_arbiter
  import proc_pkg::*;
#(
  parameter int ADDR_W = proc_pkg::ADDR_W,
  parameter int DATA_W = proc_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [15:0]       c_cnt,
  output logic [15:0]       h_cnt
);

  logic [1:0]        state_q;
  logic              last_q;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] c_rdata_q;
  logic [DATA_W-1:0] h_rdata_q;
  logic [15:0]       c_cnt_q;
  logic [15:0]       h_cnt_q;
  logic              pick_c;
  logic              pick_h;

  rr_pick2 u_pick (
    .req_a   (c_req),
    .req_b   (h_req),
    .last    (last_q),
    .grant_a (pick_c),
    .grant_b (pick_h)
  );

  // Grants and strobes; reset masks them so an aborted access never reaches
  // the memory and no grant is claimed while the registers are held in reset.
  always_comb begin
    c_gnt     = (state_q == IDLE) & ~rst & pick_c;
    h_gnt     = (state_q == IDLE) & ~rst & pick_h;
    mem_en    = (state_q == ACCESS) & ~rst;
    mem_we    = mem_en & we_q;
    mem_addr  = mem_en ? addr_q : '0;
    mem_wdata = mem_en ? wdata_q : '0;
    c_rvalid  = (state_q == RDWAIT) & ~rst & (owner_q == CORE);
    h_rvalid  = (state_q == RDWAIT) & ~rst & (owner_q == HOST);
    // Read data is forwarded in the rvalid cycle, then held from the register.
    c_rdata   = c_rvalid ? mem_rdata : c_rdata_q;
    h_rdata   = h_rvalid ? mem_rdata : h_rdata_q;
    busy      = (state_q != IDLE);
    c_cnt     = c_cnt_q;
    h_cnt     = h_cnt_q;
  end

  // FSM, request capture, round-robin pointer, read-data and grant counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= HOST;
      owner_q   <= CORE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      c_rdata_q <= '0;
      h_rdata_q <= '0;
      c_cnt_q   <= '0;
      h_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (c_gnt) begin
            owner_q <= CORE;
            last_q  <= CORE;
            we_q    <= c_we;
            addr_q  <= c_addr;
            wdata_q <= c_wdata;
            c_cnt_q <= c_cnt_q + 16'd1;
            state_q <= ACCESS;
          end else if (h_gnt) begin
            owner_q <= HOST;
            last_q  <= HOST;
            we_q    <= h_we;
            addr_q  <= h_addr;
            wdata_q <= h_wdata;
            h_cnt_q <= h_cnt_q + 16'd1;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          state_q <= we_q ? IDLE : RDWAIT;
        end
        RDWAIT: begin
          if (owner_q == CORE) c_rdata_q <= mem_rdata;
          else                 h_rdata_q <= mem_rdata;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter with a behavioural 16x16 synchronous memory.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, h_req, h_we;
  logic [3:0]  c_addr, h_addr;
  logic [15:0] c_wdata, h_wdata;
  logic        c_gnt, c_rvalid, h_gnt, h_rvalid;
  logic [15:0] c_rdata, h_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;
  logic [15:0] c_cnt, h_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .c_cnt(c_cnt), .h_cnt(h_cnt)
  );

  // memory model: write at end of strobe cycle, read data one cycle later
  logic [15:0] mem [16];
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [15:0] wdata;
  } req_t;

  req_t        c_pend[$], h_pend[$];
  bit          order_exp[$], order_got[$];
  logic [15:0] c_exp_rd[$], c_got_rd[$], h_exp_rd[$], h_got_rd[$];
  int          gnt_cyc[$];
  int          cyc = 0;
  int          busy_last = 0;
  bit          c_gnt_seen = 0, h_gnt_seen = 0, busy_seen = 0;

  task automatic queue_req(input bit host, input logic we, input logic [3:0] addr,
                           input logic [15:0] wdata);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata;
    order_exp.push_back(host);
    if (host) begin
      h_pend.push_back(r);
      if (!we) h_exp_rd.push_back(mem[addr]);
    end else begin
      c_pend.push_back(r);
      if (!we) c_exp_rd.push_back(mem[addr]);
    end
  endtask

  // one clock: refresh requests at the falling edge, then record DUT events
  task automatic cycle();
    req_t r;
    @(negedge clk);
    cyc++;
    if (!c_req || c_gnt_seen) begin
      if (c_pend.size() > 0) begin
        r = c_pend.pop_front();
        c_req = 1'b1; c_we = r.we; c_addr = r.addr; c_wdata = r.wdata;
      end else begin
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
      end
    end
    if (!h_req || h_gnt_seen) begin
      if (h_pend.size() > 0) begin
        r = h_pend.pop_front();
        h_req = 1'b1; h_we = r.we; h_addr = r.addr; h_wdata = r.wdata;
      end else begin
        h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
      end
    end
    #1;
    c_gnt_seen = c_gnt;
    h_gnt_seen = h_gnt;
    busy_seen  = busy;
    if (busy) busy_last = cyc;
    if (c_gnt) begin order_got.push_back(1'b0); gnt_cyc.push_back(cyc); end
    if (h_gnt) begin order_got.push_back(1'b1); gnt_cyc.push_back(cyc); end
    if (c_rvalid) c_got_rd.push_back(c_rdata);
    if (h_rvalid) h_got_rd.push_back(h_rdata);
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    do begin
      cycle();
      n++;
    end while ((c_pend.size() > 0 || h_pend.size() > 0 || c_req || h_req || busy_seen)
               && n < budget);
    n_cmp++;
    if (c_pend.size() > 0 || h_pend.size() > 0 || c_req || h_req || busy_seen) begin
      n_err++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
    c_gnt_seen = 0; h_gnt_seen = 0; busy_seen = 0;
    c_pend.delete(); h_pend.delete(); order_exp.delete(); order_got.delete();
    c_exp_rd.delete(); c_got_rd.delete(); h_exp_rd.delete(); h_got_rd.delete();
    gnt_cyc.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    c_req = 1'b1; h_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (c_gnt !== 1'b0 || h_gnt !== 1'b0) begin n_err++;
      $display("FAIL reset_gnt: got c=%b h=%b, required 0 0", c_gnt, h_gnt); end
    c_req = 1'b0; h_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++;
      $display("FAIL reset_busy: got %b, required 0", busy); end
    n_cmp++; if (c_cnt !== 16'd0 || h_cnt !== 16'd0) begin n_err++;
      $display("FAIL reset_cnt: got c=%h h=%h, required 0 0", c_cnt, h_cnt); end
    n_cmp++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 4'd0 || mem_wdata !== 16'd0) begin
      n_err++; $display("FAIL reset_mem: got en=%b we=%b a=%h d=%h, required all 0",
                        mem_en, mem_we, mem_addr, mem_wdata); end
    n_cmp++; if (c_rdata !== 16'd0 || h_rdata !== 16'd0 || c_rvalid !== 1'b0 || h_rvalid !== 1'b0) begin
      n_err++; $display("FAIL reset_rd: got c=%h h=%h cv=%b hv=%b, required 0", c_rdata, h_rdata,
                        c_rvalid, h_rvalid); end
  endtask

  task automatic test_preload_read();
    @(negedge clk);
    h_req = 1; h_we = 1; h_addr = 4'd1; h_wdata = 16'h0020;
    #1;
    n_cmp++; if (h_gnt !== 1'b1 || c_gnt !== 1'b0) begin n_err++;
      $display("FAIL pre_hgnt: got h=%b c=%b, required 1 0", h_gnt, c_gnt); end
    @(negedge clk);
    h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
    #1;
    n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 4'd1 || mem_wdata !== 16'h0020) begin
      n_err++; $display("FAIL pre_wr: got en=%b we=%b a=%h d=%h, required 1 1 1 0020",
                        mem_en, mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    c_req = 1; c_we = 0; c_addr = 4'd1;
    #1;
    n_cmp++; if (c_gnt !== 1'b1) begin n_err++;
      $display("FAIL pre_cgnt: got %b, required 1", c_gnt); end
    @(negedge clk);
    c_req = 0; c_addr = '0;
    #1;
    n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 4'd1 || c_rvalid !== 1'b0) begin
      n_err++; $display("FAIL pre_rd: got en=%b we=%b a=%h rv=%b, required 1 0 1 0",
                        mem_en, mem_we, mem_addr, c_rvalid); end
    @(negedge clk);
    #1;
    n_cmp++; if (c_rvalid !== 1'b1 || c_rdata !== 16'h0020 || h_rvalid !== 1'b0) begin
      n_err++; $display("FAIL pre_rdata: got cv=%b d=%h hv=%b, required 1 0020 0",
                        c_rvalid, c_rdata, h_rvalid); end
    @(negedge clk);
    #1;
    n_cmp++; if (c_rvalid !== 1'b0 || c_rdata !== 16'h0020 || busy !== 1'b0) begin
      n_err++; $display("FAIL pre_hold: got cv=%b d=%h busy=%b, required 0 0020 0",
                        c_rvalid, c_rdata, busy); end
  endtask

  task automatic check_order(input string name);
    bit e, g;
    while (order_exp.size() > 0) begin
      e = order_exp.pop_front();
      g = (order_got.size() > 0) ? order_got.pop_front() : ~e;
      n_cmp++; if (g !== e) begin n_err++;
        $display("FAIL %s_order: got %s, required %s", name, g ? "H" : "C", e ? "H" : "C"); end
    end
  endtask

  task automatic check_rdata(input string name);
    logic [15:0] e, g;
    while (c_exp_rd.size() > 0) begin
      e = c_exp_rd.pop_front();
      g = (c_got_rd.size() > 0) ? c_got_rd.pop_front() : 16'hxxxx;
      n_cmp++; if (g !== e) begin n_err++;
        $display("FAIL %s_crdata: got %h, required %h", name, g, e); end
    end
    while (h_exp_rd.size() > 0) begin
      e = h_exp_rd.pop_front();
      g = (h_got_rd.size() > 0) ? h_got_rd.pop_front() : 16'hxxxx;
      n_cmp++; if (g !== e) begin n_err++;
        $display("FAIL %s_hrdata: got %h, required %h", name, g, e); end
    end
  endtask

  task automatic test_simul_reads();
    int g0, g1;
    do_reset();
    queue_req(1'b0, 1'b0, 4'd1, 16'h0);
    queue_req(1'b1, 1'b0, 4'd1, 16'h0);
    drain(40, "simul");
    g0 = (gnt_cyc.size() > 0) ? gnt_cyc[0] : 0;
    g1 = (gnt_cyc.size() > 1) ? gnt_cyc[1] : 0;
    check_order("simul");
    check_rdata("simul");
    n_cmp++; if (g1 - g0 !== 3) begin n_err++;
      $display("FAIL simul_gap: got %0d cycles between grants, required 3", g1 - g0); end
    n_cmp++; if (c_cnt !== 16'd1 || h_cnt !== 16'd1) begin n_err++;
      $display("FAIL simul_cnt: got c=%0d h=%0d, required 1 1", c_cnt, h_cnt); end
  endtask

  task automatic test_back_to_back();
    int glast;
    gnt_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      queue_req(1'b0, 1'b1, 4'(8 + i), 16'hC000 + 16'(i));
      queue_req(1'b1, 1'b1, 4'(11 + i), 16'hA000 + 16'(i));
    end
    drain(60, "b2b");
    check_order("b2b");
    for (int i = 1; i < 6; i++) begin
      n_cmp++;
      if (i >= gnt_cyc.size() || gnt_cyc[i] - gnt_cyc[i-1] != 2) begin n_err++;
        $display("FAIL b2b_gap%0d: got %0d, required 2", i,
                 (i < gnt_cyc.size()) ? gnt_cyc[i] - gnt_cyc[i-1] : -1); end
    end
    glast = (gnt_cyc.size() > 0) ? gnt_cyc[gnt_cyc.size()-1] : 0;
    n_cmp++; if (busy_last !== glast + 1) begin n_err++;
      $display("FAIL b2b_busy: got last busy cycle %0d, required %0d", busy_last, glast + 1); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (mem[8+i] !== 16'hC000 + 16'(i) || mem[11+i] !== 16'hA000 + 16'(i)) begin
        n_err++; $display("FAIL b2b_mem%0d: got %h %h, required %h %h", i, mem[8+i], mem[11+i],
                          16'hC000 + 16'(i), 16'hA000 + 16'(i)); end
    end
    n_cmp++; if (c_cnt !== 16'd4 || h_cnt !== 16'd4) begin n_err++;
      $display("FAIL b2b_cnt: got c=%0d h=%0d, required 4 4", c_cnt, h_cnt); end
  endtask

  task automatic test_same_addr();
    int n = 0;
    req_t r;
    r.we = 1'b1; r.addr = 4'd4; r.wdata = 16'h1C3A;
    order_exp.push_back(1'b1);
    h_pend.push_back(r);
    do begin cycle(); n++; end while (!h_gnt_seen && n < 10);
    // the host write is now in flight; the core read of the same word follows
    order_exp.push_back(1'b0);
    r.we = 1'b0; r.wdata = 16'h0;
    c_pend.push_back(r);
    c_exp_rd.push_back(16'h1C3A);
    drain(40, "same");
    check_order("same");
    check_rdata("same");
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    @(negedge clk);
    c_req = 1; c_we = 0; c_addr = 4'd4;
    #1;
    n_cmp++; if (c_gnt !== 1'b1) begin n_err++;
      $display("FAIL midrst_gnt: got %b, required 1", c_gnt); end
    @(negedge clk);
    c_req = 0; c_addr = '0; rst = 1'b1;
    #1;
    n_cmp++; if (mem_en !== 1'b0 || c_rvalid !== 1'b0) begin n_err++;
      $display("FAIL midrst_access: got en=%b rv=%b, required 0 0", mem_en, c_rvalid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || mem_en !== 1'b0 || c_rvalid !== 1'b0) begin n_err++;
      $display("FAIL midrst_idle: got busy=%b en=%b rv=%b, required 0 0 0", busy, mem_en, c_rvalid); end
    n_cmp++; if (c_cnt !== 16'd0 || h_cnt !== 16'd0) begin n_err++;
      $display("FAIL midrst_cnt: got c=%0d h=%0d, required 0 0", c_cnt, h_cnt); end
    @(negedge clk);
    #1;
    n_cmp++; if (c_rvalid !== 1'b0 || mem_en !== 1'b0) begin n_err++;
      $display("FAIL midrst_after: got rv=%b en=%b, required 0 0", c_rvalid, mem_en); end
  endtask

  task automatic test_counter_wrap();
    @(negedge clk);
    force dut.c_cnt_q = 16'hFFFF;
    #1;
    release dut.c_cnt_q;
    queue_req(1'b0, 1'b1, 4'd2, 16'h5555);
    drain(20, "wrap");
    check_order("wrap");
    n_cmp++; if (c_cnt !== 16'h0000) begin n_err++;
      $display("FAIL wrap_cnt: got %h, required 0000", c_cnt); end
    queue_req(1'b0, 1'b0, 4'd2, 16'h0);
    drain(20, "wrap2");
    check_order("wrap2");
    check_rdata("wrap2");
    n_cmp++; if (c_cnt !== 16'h0001 || h_cnt !== 16'h0000) begin n_err++;
      $display("FAIL wrap_next: got c=%h h=%h, required 0001 0000", c_cnt, h_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    mem_rdata = 16'h0;
    test_reset();
    test_preload_read();
    test_simul_reads();
    test_back_to_back();
    test_same_addr();
    test_reset_mid_read();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
